// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers, used beside the EX-stage ALU.
// A mult/div is captured on Start, held for a fixed latency, then written to HI/LO.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [2:0]  i_mdOp,
    input  logic        i_start,
    input  logic        i_hiLoSel,
    output logic        o_busy,
    output logic [31:0] o_out
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic [31:0]       r_a;
    logic [31:0]       r_b;
    logic [31:0]       r_hi;
    logic [31:0]       r_lo;

    logic              w_mtWrite;
    logic              w_accept;
    logic              w_done;
    logic              w_isMult;
    logic              w_isSigned;
    logic              w_divByZero;
    logic [63:0]       w_aExt;
    logic [63:0]       w_bExt;
    logic [63:0]       w_prod;
    logic              w_aNeg;
    logic              w_bNeg;
    logic [31:0]       w_aMag;
    logic [31:0]       w_bMag;
    logic [31:0]       w_quoMag;
    logic [31:0]       w_remMag;
    logic [31:0]       w_quo;
    logic [31:0]       w_rem;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // mthi/mtlo share the MDOp field with mult/div, so a move always beats Start.
    always_comb begin
        w_nextState = r_state;
        w_mtWrite   = 1'b0;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                w_mtWrite = (i_mdOp == OP_MTHI) || (i_mdOp == OP_MTLO);
                w_accept  = i_start && !w_mtWrite &&
                            (i_mdOp >= OP_MULT) && (i_mdOp <= OP_DIVU);
                if (w_accept) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                w_done = (r_cnt == '0);
                if (w_done) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    assign w_isMult    = (r_op == OP_MULT) || (r_op == OP_MULTU);
    assign w_isSigned  = (r_op == OP_MULT) || (r_op == OP_DIV);
    assign w_divByZero = !w_isMult && (r_b == 32'd0);

    // Low 64 bits of a 64x64 product are correct for both signed and unsigned.
    assign w_aExt = {{32{w_isSigned & r_a[31]}}, r_a};
    assign w_bExt = {{32{w_isSigned & r_b[31]}}, r_b};
    assign w_prod = w_aExt * w_bExt;

    // Signed divide through magnitudes avoids the 0x80000000 / -1 overflow case.
    assign w_aNeg   = w_isSigned & r_a[31];
    assign w_bNeg   = w_isSigned & r_b[31];
    assign w_aMag   = w_aNeg ? -r_a : r_a;
    assign w_bMag   = w_bNeg ? -r_b : r_b;
    assign w_quoMag = (w_bMag == 32'd0) ? 32'd0 : (w_aMag / w_bMag);
    assign w_remMag = (w_bMag == 32'd0) ? 32'd0 : (w_aMag % w_bMag);
    assign w_quo    = (w_aNeg ^ w_bNeg) ? -w_quoMag : w_quoMag;
    assign w_rem    = w_aNeg ? -w_remMag : w_remMag;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            if (w_accept) begin
                r_op <= i_mdOp;
                r_a  <= i_a;
                r_b  <= i_b;
                if ((i_mdOp == OP_MULT) || (i_mdOp == OP_MULTU)) begin
                    r_cnt <= CNT_W'(MULT_CYCLES - 1);
                end else begin
                    r_cnt <= CNT_W'(DIV_CYCLES - 1);
                end
            end else if ((r_state == RUN) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_mtWrite && (i_mdOp == OP_MTHI)) begin
                r_hi <= i_a;
            end
            if (w_mtWrite && (i_mdOp == OP_MTLO)) begin
                r_lo <= i_a;
            end

            if (w_done && !w_divByZero) begin
                if (w_isMult) begin
                    r_hi <= w_prod[63:32];
                    r_lo <= w_prod[31:0];
                end else begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end
            end
        end
    end

    assign o_busy = (r_state == RUN);
    assign o_out  = i_hiLoSel ? r_hi : r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit: latency, arithmetic results, HI/LO moves,
// ignored Start while busy, divide-by-zero and reset abort.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  mdOp;
    logic        start;
    logic        hiLoSel;
    logic        busy;
    logic [31:0] out;

    int checkCount;
    int errorCount;

    mult_div_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_a      (a),
        .i_b      (b),
        .i_mdOp   (mdOp),
        .i_start  (start),
        .i_hiLoSel(hiLoSel),
        .o_busy   (busy),
        .o_out    (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkHiLo(input string tag, input logic [31:0] expHi,
                             input logic [31:0] expLo);
        hiLoSel = 1'b1;
        #1;
        checkOutput({tag, " HI"}, out, expHi);
        hiLoSel = 1'b0;
        #1;
        checkOutput({tag, " LO"}, out, expLo);
    endtask

    task automatic writeHiLo(input logic [2:0] op, input logic [31:0] value);
        @(negedge clk);
        mdOp = op;
        a    = value;
        @(negedge clk);
        mdOp = 3'd0;
    endtask

    // Operands are inverted after acceptance to show they were captured.
    task automatic applyStimulus(input string tag, input logic [2:0] op,
                                 input logic [31:0] opA, input logic [31:0] opB,
                                 input int expCycles);
        int cycles;
        @(negedge clk);
        mdOp  = op;
        a     = opA;
        b     = opB;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        mdOp   = 3'd0;
        a      = ~opA;
        b      = ~opB;
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        checkOutput({tag, " busy cycles"}, 32'(cycles), 32'(expCycles));
    endtask

    initial begin
        int cycles;
        checkCount = 0;
        errorCount = 0;
        reset   = 1'b1;
        a       = '0;
        b       = '0;
        mdOp    = '0;
        start   = 1'b0;
        hiLoSel = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkHiLo("reset", 32'h0, 32'h0);
        reset = 1'b0;

        applyStimulus("mult", 3'd1, 32'hFFFFFFFE, 32'd3, 5);
        checkHiLo("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);

        applyStimulus("multu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5);
        checkHiLo("multu", 32'hFFFFFFFE, 32'h00000001);

        applyStimulus("div", 3'd3, 32'hFFFFFFF9, 32'd2, 10);
        checkHiLo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

        applyStimulus("divu", 3'd4, 32'hFFFFFFF9, 32'd2, 10);
        checkHiLo("divu", 32'h00000001, 32'h7FFFFFFC);

        applyStimulus("div pos/neg", 3'd3, 32'd7, 32'hFFFFFFFE, 10);
        checkHiLo("div pos/neg", 32'h00000001, 32'hFFFFFFFD);

        applyStimulus("div overflow", 3'd3, 32'h80000000, 32'hFFFFFFFF, 10);
        checkHiLo("div overflow", 32'h00000000, 32'h80000000);

        writeHiLo(3'd5, 32'h11);
        writeHiLo(3'd6, 32'h22);
        checkHiLo("mthi/mtlo", 32'h11, 32'h22);
        applyStimulus("divu by zero", 3'd4, 32'h1234, 32'd0, 10);
        checkHiLo("divu by zero", 32'h11, 32'h22);

        // Start with MDOp=mthi: no operation starts, HI is written
        @(negedge clk);
        mdOp  = 3'd5;
        a     = 32'h33;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mdOp  = 3'd0;
        checkOutput("start+mthi busy", 32'(busy), 32'd0);
        checkHiLo("start+mthi", 32'h33, 32'h22);

        // Mult start and mtlo issued while a div is running are both ignored
        @(negedge clk);
        mdOp  = 3'd3;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        mdOp   = 3'd0;
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            start = 1'b0;
            mdOp  = 3'd0;
            if (cycles == 3) begin
                start = 1'b1;
                mdOp  = 3'd1;
                a     = 32'd9;
                b     = 32'd9;
            end else if (cycles == 4) begin
                mdOp = 3'd6;
                a    = 32'd5;
            end
            @(negedge clk);
        end
        start = 1'b0;
        mdOp  = 3'd0;
        checkOutput("div ignore busy cycles", 32'(cycles), 32'd10);
        checkHiLo("div ignore", 32'd2, 32'd14);
        @(negedge clk);
        checkOutput("div ignore busy after", 32'(busy), 32'd0);

        // Reset during the second cycle of a mult aborts it
        @(negedge clk);
        mdOp  = 3'd1;
        a     = 32'd3;
        b     = 32'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mdOp  = 3'd0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("reset abort busy", 32'(busy), 32'd0);
        checkHiLo("reset abort", 32'h0, 32'h0);

        applyStimulus("mult after reset", 3'd1, 32'd7, 32'd6, 5);
        checkHiLo("mult after reset", 32'h0, 32'd42);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
